// File: rtl/digi_ota_array.sv
// Clocked multi-channel digital comparator: sync, glitch filter,
// tie hysteresis and explicit output enable per channel.
module digi_ota_array #(
  parameter int CHANNELS    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                hold_mode,
  input  logic [CHANNELS-1:0] vip,
  input  logic [CHANNELS-1:0] vin,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] out_oe,
  output logic [CHANNELS-1:0] out_edge
);

  localparam logic [1:0] D_TIE = 2'd0;
  localparam logic [1:0] D_UP  = 2'd1;
  localparam logic [1:0] D_DN  = 2'd2;

  localparam logic [1:0] S_TIE  = 2'd0;
  localparam logic [1:0] S_HIGH = 2'd1;
  localparam logic [1:0] S_LOW  = 2'd2;

  localparam logic [3:0] FL = 4'(FILTER_LEN);

  logic [SYNC_STAGES-1:0][CHANNELS-1:0] p_sync;
  logic [SYNC_STAGES-1:0][CHANNELS-1:0] n_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      p_sync <= '0;
      n_sync <= '0;
    end else begin
      p_sync <= {p_sync[SYNC_STAGES-2:0], vip};
      n_sync <= {n_sync[SYNC_STAGES-2:0], vin};
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic       p, n;
    logic [1:0] d;
    logic [1:0] cand, cand_n;
    logic [3:0] cnt, cnt_n;
    logic [1:0] fsm, fsm_n;
    logic       dec, dec_n;
    logic       o, o_n;
    logic       oe, oe_n;
    logic       ev, ev_n;

    assign p = p_sync[SYNC_STAGES-1][i];
    assign n = n_sync[SYNC_STAGES-1][i];

    always_comb begin
      d = D_TIE;
      unique case (1'b1)
        p & ~n:  d = D_UP;
        ~p & n:  d = D_DN;
        default: d = D_TIE;
      endcase
    end

    always_comb begin
      cand_n = cand;
      cnt_n  = cnt;
      fsm_n  = fsm;
      dec_n  = dec;
      o_n    = o;
      oe_n   = oe;
      ev_n   = 1'b0;
      if (!en) begin
        cand_n = D_TIE;
        cnt_n  = 4'd0;
        fsm_n  = S_TIE;
        oe_n   = 1'b0;
      end else begin
        if (d == cand) begin
          cnt_n = (cnt == FL) ? FL : cnt + 4'd1;
        end else begin
          cand_n = d;
          cnt_n  = 4'd1;
        end
        // saturated re-commits land in the same state, so no edge guard
        if (cnt_n == FL) begin
          unique case (cand_n)
            D_UP:    fsm_n = S_HIGH;
            D_DN:    fsm_n = S_LOW;
            default: fsm_n = S_TIE;
          endcase
        end
        if (fsm_n != S_TIE) dec_n = 1'b1;
        unique case (1'b1)
          fsm_n == S_HIGH: begin
            o_n  = 1'b1;
            oe_n = 1'b1;
          end
          fsm_n == S_LOW: begin
            o_n  = 1'b0;
            oe_n = 1'b1;
          end
          default: oe_n = hold_mode & dec_n;
        endcase
        ev_n = o_n ^ o;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        cand <= D_TIE;
        cnt  <= 4'd0;
        fsm  <= S_TIE;
        dec  <= 1'b0;
        o    <= 1'b0;
        oe   <= 1'b0;
        ev   <= 1'b0;
      end else begin
        cand <= cand_n;
        cnt  <= cnt_n;
        fsm  <= fsm_n;
        dec  <= dec_n;
        o    <= o_n;
        oe   <= oe_n;
        ev   <= ev_n;
      end
    end

    assign out[i]      = o;
    assign out_oe[i]   = oe;
    assign out_edge[i] = ev;
  end

endmodule

// File: doc/digi_ota_array.md
Name: digi_ota_array

Overview:
- Clocked, parametrised successor to the gate-level digital OTA/comparator.
- Per channel, compares a non-inverting and an inverting digital-level input, then drives a decision output with an explicit output enable instead of a tri-state primitive.
- Adds input synchronisation, a glitch filter, hysteretic hold on ties, a global enable and a one-cycle change-event flag.
- Sits between the pad-level comparator inputs and the uo_out/uio_oe drive logic of the top wrapper.

Parameters:
- CHANNELS, 4, number of independent comparator channels (1..8).
- SYNC_STAGES, 2, flops in each input synchroniser chain (min 2).
- FILTER_LEN, 4, consecutive equal samples needed to commit a decision (min 1, max 15).

Ports:
- clk  input  1  system clock, all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  global enable; low forces all channels to idle-tie.
- hold_mode  input  1  1 = keep driving the last decision on tie; 0 = release drive on tie.
- vip  input  CHANNELS  non-inverting inputs, asynchronous.
- vin  input  CHANNELS  inverting inputs, asynchronous.
- out  output  CHANNELS  registered decision value.
- out_oe  output  CHANNELS  registered drive enable (1 = drive out).
- edge  output  CHANNELS  one-cycle pulse when out[i] changes.

Behaviour:
- Reset (rst=1 at a clock edge):
  - All synchroniser flops = 0.
  - Filter cand = TIE, cnt = 0, FSM = TIE.
  - out = 0, out_oe = 0, edge = 0.
  - Reset mid-filter discards the partial count.
- Synchroniser: each vip[i] and vin[i] passes through SYNC_STAGES flops. Only the final stage feeds logic. The chain runs regardless of en.
- Raw decision d[i] from the synced pair (p,n):
  - p=1, n=0 -> UP.
  - p=0, n=1 -> DN.
  - p=n -> TIE.
- Filter per channel:
  - Holds cand (2 bits) and cnt, 4 bits, saturating at FILTER_LEN.
  - Each edge with en=1: if d==cand then cnt <= min(cnt+1, FILTER_LEN); else cand <= d and cnt <= 1.
  - A decision commits at the edge where cnt becomes FILTER_LEN. For FILTER_LEN=1 this is the first edge on which d differs from cand.
- FSM per channel, states TIE / HIGH / LOW:
  - Commit UP -> HIGH, commit DN -> LOW, commit TIE -> TIE.
  - Any state may go to any other state.
  - Re-committing the current state has no effect.
- Outputs, registered and updated on the same edge as the commit:
  - HIGH: out=1, oe=1.
  - LOW: out=0, oe=1.
  - TIE: out holds its previous value; oe = hold_mode & decided[i].
  - decided[i] is set on the first HIGH/LOW commit and cleared by rst only.
  - hold_mode is sampled every cycle, so a change of hold_mode while in TIE updates oe on the next edge.
- edge[i] = 1 for exactly one cycle after any edge where out[i] changed value. It does not pulse on oe-only changes.
- Latency: an input change set up before edge E1 and held stable is visible on out/out_oe after edge E(SYNC_STAGES+FILTER_LEN).
- Glitch rejection: a decision lasting fewer than FILTER_LEN synced cycles never reaches out.
- en=0 at an edge:
  - cnt <= 0, cand <= TIE, FSM <= TIE.
  - oe <= 0 regardless of hold_mode; out holds; edge <= 0.
  - When en returns to 1, filtering restarts from cnt=0.
- rst and en=0 together: rst wins.
- Channels are fully independent. Simultaneous commits on several channels are all applied on the same edge.

Test Plan:
- Reset release: rst=1 for 2 cycles, vip=vin=0 -> out=0, out_oe=0, edge=0 for all 4 channels (CHANNELS=4, SYNC_STAGES=2, FILTER_LEN=3).
- Clean UP then DN on ch0: vip[0]=1, vin[0]=0 from E1 -> out[0]=1, oe[0]=1, edge[0] pulse after E5. Then swap the inputs -> out[0]=0 and an edge pulse 5 edges later.
- Glitch: ch1 in LOW, vip[1]=1/vin[1]=0 for 2 cycles then back -> out[1]=0, edge[1] never asserted. A 3-cycle pulse -> out[1]=1 after 5 edges.
- Tie hold/release: ch2 in HIGH, vip=vin=1 with hold_mode=1 -> out=1, oe=1 indefinitely. Set hold_mode=0 -> oe=0 next edge, out stays 1.
- Enable drop mid-filter: ch3 at cnt=2 toward UP, en=0 one cycle -> oe=0. After en=1, a full 3 consistent samples are needed before out[3]=1.
- Parallel plus reset: all channels UP simultaneously -> all commit on the same edge. Assert rst during a later DN filter -> all outputs 0 and decided cleared.
